// File: rtl/ram_master_pkg.sv
// Shared types for the burst RAM master: FSM state encoding and credit-counter sizing.
package ram_master_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   localparam int DEF_RSP_DEPTH = 4;
   localparam int DEF_CRD_W     = $clog2(DEF_RSP_DEPTH + 1);

   // Width able to hold 0..depth, used for FIFO occupancy and read credits.
   function automatic int crdWidth(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Small synchronous FIFO holding read responses ({data, last}) until the client takes them.
module ram_rsp_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] headData_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0] count_q;
   logic             doPush, doPop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign doPop  = pop_i && (count_q != '0);
   assign doPush = push_i && (count_q != CNT_W'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
         if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= pushData_i;
   end

   assign headData_o = mem_q[rdPtr_q];
   assign count_o    = count_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst read/write master for a single-port separate-I/O RAM; reads return through a credit-
// managed response FIFO so client backpressure stalls issue instead of losing data.
module ram_burst_master
   import ram_master_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int LEN_WIDTH    = 4,
   parameter int READ_LATENCY = 1,
   parameter int RSP_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  busy,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   localparam int CW = crdWidth(RSP_DEPTH);
   localparam int LW = $clog2(READ_LATENCY + 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } rspEntry_t;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   curAddr_q;
   logic [LEN_WIDTH-1:0]    beatsLeft_q;
   logic                    cmdReady_q, wrReady_q;
   logic [READ_LATENCY-1:0] pipeVld_q, pipeLast_q;
   logic                    wrAccept, issue, issueLast;
   logic [LW-1:0]           inflight;
   logic [CW-1:0]           fifoCount;
   logic [CW:0]             credit;
   rspEntry_t               pushEntry, headEntry;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + LW'(pipeVld_q[i]);
   end

   // Reads already in the RAM pipe reserve FIFO space, so a push can never find it full.
   assign credit    = (CW+1)'(RSP_DEPTH) - (CW+1)'(fifoCount) - (CW+1)'(inflight);
   assign issue     = (state_q == READ) && (credit != '0);
   assign issueLast = (beatsLeft_q == '0);
   assign wrAccept  = wrReady_q && wr_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         curAddr_q   <= '0;
         beatsLeft_q <= '0;
         cmdReady_q  <= 1'b0;
         wrReady_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmdReady_q && cmd_valid) begin
                  curAddr_q   <= cmd_addr;
                  beatsLeft_q <= cmd_len;
                  cmdReady_q  <= 1'b0;
                  if (cmd_write) begin
                     state_q   <= WRITE;
                     wrReady_q <= 1'b1;
                  end else begin
                     state_q   <= READ;
                  end
               end else begin
                  cmdReady_q <= 1'b1;
               end
            end
            WRITE: begin
               if (wrAccept) begin
                  curAddr_q   <= curAddr_q + ADDR_WIDTH'(1);
                  beatsLeft_q <= beatsLeft_q - LEN_WIDTH'(1);
                  if (issueLast) begin
                     state_q    <= IDLE;
                     wrReady_q  <= 1'b0;
                     cmdReady_q <= 1'b1;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  curAddr_q   <= curAddr_q + ADDR_WIDTH'(1);
                  beatsLeft_q <= beatsLeft_q - LEN_WIDTH'(1);
                  if (issueLast) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (inflight == '0) begin
                  state_q    <= IDLE;
                  cmdReady_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tags travel alongside the RAM read latency so data and 'last' arrive together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipeVld_q  <= '0;
         pipeLast_q <= '0;
      end else begin
         pipeVld_q[0]  <= issue;
         pipeLast_q[0] <= issue && issueLast;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipeVld_q[i]  <= pipeVld_q[i-1];
            pipeLast_q[i] <= pipeLast_q[i-1];
         end
      end
   end

   assign pushEntry = '{data: ram_data_out, last: pipeLast_q[READ_LATENCY-1]};

   ram_rsp_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (RSP_DEPTH),
      .CNT_W (CW)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (pipeVld_q[READ_LATENCY-1]),
      .pushData_i (pushEntry),
      .pop_i      (rd_valid && rd_ready),
      .headData_o (headEntry),
      .count_o    (fifoCount)
   );

   assign cmd_ready   = cmdReady_q;
   assign wr_ready    = wrReady_q;
   assign ram_we      = wrAccept;
   assign ram_addr    = curAddr_q;
   assign ram_data_in = wrAccept ? wr_data : '0;
   assign rd_valid    = (fifoCount != '0);
   assign rd_data     = rd_valid ? headEntry.data : '0;
   assign rd_last     = rd_valid && headEntry.last;
   assign busy        = (state_q != IDLE) || rd_valid;

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: behavioural RAM, read scoreboard, table of bursts
// plus hand-written reset-abort and read-then-write ordering sequences.
module tb_ram_burst_master;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int LW = 4;
   localparam int RL = 1;
   localparam int RD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_last, busy, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data_in, ram_data_out;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      logic [DW-1:0] seed;
      int            rdMode;
      logic [DW-1:0] expHead;
   } vec_t;

   exp_t          expQ[$];
   logic [DW-1:0] ramMem    [256];
   logic [DW-1:0] shadowMem [256];
   logic [DW-1:0] firstBeatData;
   int checks = 0, errors = 0;
   int cycle = 0, weCount = 0, issueCnt = 0, hazardCnt = 0, fifoOver = 0;
   int beatCnt = 0, firstBeatCyc = 0, lastBeatCyc = 0, rdMode = 0;

   always #5 clk = ~clk;

   ram_burst_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .READ_LATENCY(RL), .RSP_DEPTH(RD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   // Behavioural single-port RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_we) ramMem[ram_addr] <= ram_data_in;
      ram_data_out <= ramMem[ram_addr];
   end

   always @(posedge clk) cycle++;

   // Client read-ready pattern: always ready, or ready one cycle in three.
   always @(posedge clk) begin
      #1;
      rd_ready = (rdMode == 0) ? 1'b1 : ((cycle % 3) == 0);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: scoreboard pops on each read handshake, plus write/hazard/occupancy counters.
   always @(negedge clk) begin
      if (ram_we) begin
         weCount++;
         if (dut.inflight != 0) hazardCnt++;
      end
      if (dut.issue) issueCnt++;
      if (int'(dut.u_fifo.count_o) > RD) fifoOver++;
      if (rd_valid && rd_ready) begin
         beatCnt++;
         if (beatCnt == 1) begin
            firstBeatCyc  = cycle;
            firstBeatData = rd_data;
         end
         lastBeatCyc = cycle;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got %0h, expected no beat", rd_data);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("rd_data", 32'(rd_data), 32'(e.data));
            checkOutput("rd_last", 32'(rd_last), 32'(e.last));
         end
      end
   end

   task automatic sendCmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
      int guard;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 500) begin
         guard++;
         @(negedge clk);
      end
      if (guard >= 500) checkOutput("cmd_timeout", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic writeBurst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input logic [DW-1:0] seed);
      int guard;
      sendCmd(1'b1, addr, len);
      for (int i = 0; i <= int'(len); i++) begin
         wr_valid = 1'b1;
         wr_data  = seed + DW'(i);
         shadowMem[addr + AW'(i)] = seed + DW'(i);
         guard = 0;
         @(negedge clk);
         while (!wr_ready && guard < 100) begin
            guard++;
            @(negedge clk);
         end
         if (guard >= 100) checkOutput("wr_timeout", 32'(wr_ready), 32'd1);
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic startRead(input logic [AW-1:0] addr, input logic [LW-1:0] len);
      for (int i = 0; i <= int'(len); i++)
         expQ.push_back('{data: shadowMem[addr + AW'(i)], last: (i == int'(len))});
      sendCmd(1'b0, addr, len);
   endtask

   task automatic waitIdle();
      int guard = 0;
      @(negedge clk);
      while ((expQ.size() != 0 || busy) && guard < 2000) begin
         guard++;
         @(negedge clk);
      end
      if (guard >= 2000) checkOutput("idle_timeout", 32'(expQ.size()), 32'd0);
   endtask

   task automatic applyStimulus(input vec_t v);
      rdMode  = v.rdMode;
      weCount = 0;
      beatCnt = 0;
      if (v.wr) begin
         writeBurst(v.addr, v.len, v.seed);
         waitIdle();
         checkOutput("we_cycles", 32'(weCount), 32'(v.len) + 1);
         for (int i = 0; i <= int'(v.len); i++)
            checkOutput("ram_content", 32'(ramMem[v.addr + AW'(i)]), 32'(v.seed + DW'(i)));
         checkOutput("ram_head", 32'(ramMem[v.addr]), 32'(v.expHead));
      end else begin
         startRead(v.addr, v.len);
         waitIdle();
         checkOutput("rd_beats", 32'(beatCnt), 32'(v.len) + 1);
         checkOutput("rd_first", 32'(firstBeatData), 32'(v.expHead));
         if (v.rdMode == 0)
            checkOutput("rd_full_rate", 32'(lastBeatCyc - firstBeatCyc), 32'(v.len));
      end
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{wr: 1'b1, addr: 8'h10, len: 4'd3,  seed: 8'hA1, rdMode: 0, expHead: 8'hA1};
      vecs[1] = '{wr: 1'b0, addr: 8'h10, len: 4'd3,  seed: 8'h00, rdMode: 0, expHead: 8'hA1};
      vecs[2] = '{wr: 1'b1, addr: 8'hFE, len: 4'd2,  seed: 8'h01, rdMode: 0, expHead: 8'h01};
      vecs[3] = '{wr: 1'b0, addr: 8'hFE, len: 4'd2,  seed: 8'h00, rdMode: 0, expHead: 8'h01};
      vecs[4] = '{wr: 1'b1, addr: 8'h40, len: 4'd0,  seed: 8'h5A, rdMode: 0, expHead: 8'h5A};
      vecs[5] = '{wr: 1'b0, addr: 8'h40, len: 4'd0,  seed: 8'h00, rdMode: 0, expHead: 8'h5A};
      vecs[6] = '{wr: 1'b1, addr: 8'h80, len: 4'd15, seed: 8'h30, rdMode: 0, expHead: 8'h30};
      vecs[7] = '{wr: 1'b0, addr: 8'h80, len: 4'd15, seed: 8'h00, rdMode: 1, expHead: 8'h30};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("reset_rd_valid",  32'(rd_valid),  32'd0);
      checkOutput("reset_busy",      32'(busy),      32'd0);
      checkOutput("reset_ram_we",    32'(ram_we),    32'd0);
      checkOutput("reset_ram_addr",  32'(ram_addr),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("cmd_ready_first", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      checkOutput("cmd_ready_next",  32'(cmd_ready), 32'd1);

      foreach (vecs[i]) applyStimulus(vecs[i]);
      checkOutput("wrap_ram_00", 32'(ramMem[8'h00]), 32'h03);
      checkOutput("fifo_overflow", 32'(fifoOver), 32'd0);

      // Reset in the middle of a read burst: nothing queued or in flight may survive.
      rdMode   = 0;
      issueCnt = 0;
      startRead(8'h80, 4'd7);
      begin
         int guard = 0;
         @(negedge clk);
         while (issueCnt < 3 && guard < 100) begin
            guard++;
            @(negedge clk);
         end
         if (guard >= 100) checkOutput("issue_timeout", 32'(issueCnt), 32'd3);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      expQ.delete();
      @(negedge clk);
      checkOutput("abort_rd_valid",  32'(rd_valid),  32'd0);
      checkOutput("abort_busy",      32'(busy),      32'd0);
      checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      rst_n   = 1'b1;
      beatCnt = 0;
      repeat (20) @(negedge clk);
      checkOutput("stale_beats", 32'(beatCnt), 32'd0);
      checkOutput("post_abort_busy", 32'(busy), 32'd0);
      applyStimulus('{wr: 1'b0, addr: 8'h80, len: 4'd7, seed: 8'h00, rdMode: 0, expHead: 8'h30});

      // Read immediately followed by a write to the same range.
      hazardCnt = 0;
      weCount   = 0;
      beatCnt   = 0;
      startRead(8'h10, 4'd3);
      writeBurst(8'h10, 4'd3, 8'hB1);
      waitIdle();
      checkOutput("hazard_writes", 32'(hazardCnt), 32'd0);
      checkOutput("hazard_we_cycles", 32'(weCount), 32'd4);
      checkOutput("hazard_old_data", 32'(firstBeatData), 32'hA1);
      applyStimulus('{wr: 1'b0, addr: 8'h10, len: 4'd3, seed: 8'h00, rdMode: 0, expHead: 8'hB1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
